// File: rtl/pixel_array_controller_if.sv
// Control/readout bundle between the pixel array sequencer (master) and its
// pixel array / frame collector (slave).
interface pixel_array_controller_if #(
  parameter int PIXEL_BITS = 8,
  parameter int ROWS       = 2
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                  START;
  logic                  ROW_READY;
  logic                  ERASE;
  logic                  EXPOSE;
  logic                  CONVERT;
  logic [PIXEL_BITS-1:0] DIGITAL_RAMP;
  logic [ROWS-1:0]       READ_ROW;
  logic                  ROW_VALID;
  logic [RW-1:0]         ROW_INDEX;
  logic                  BUSY;
  logic                  FRAME_DONE;

  modport master (
    input  START, ROW_READY,
    output ERASE, EXPOSE, CONVERT, DIGITAL_RAMP, READ_ROW, ROW_VALID,
           ROW_INDEX, BUSY, FRAME_DONE
  );

  modport slave (
    output START, ROW_READY,
    input  ERASE, EXPOSE, CONVERT, DIGITAL_RAMP, READ_ROW, ROW_VALID,
           ROW_INDEX, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then a
// valid/ready row readout. Every output is a register loaded from next-state.
module pixel_array_controller #(
  parameter int PIXEL_BITS    = 8,
  parameter int ROWS          = 2,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  pixel_array_controller_if.master   bus
);
  localparam int RAMP_CYCLES = 1 << PIXEL_BITS;
  localparam int MAXEX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAXC  = (MAXEX > RAMP_CYCLES) ? MAXEX : RAMP_CYCLES;
  localparam int CW    = $clog2(MAXC);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  xfer;

  logic                  erase_q, erase_d;
  logic                  expose_q, expose_d;
  logic                  convert_q, convert_d;
  logic [PIXEL_BITS-1:0] ramp_q, ramp_d;
  logic [ROWS-1:0]       read_row_q, read_row_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  assign xfer = (state_q == S_READ) && valid_q && bus.ROW_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      convert_q  <= 1'b0;
      ramp_q     <= '0;
      read_row_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      erase_q    <= erase_d;
      expose_q   <= expose_d;
      convert_q  <= convert_d;
      ramp_q     <= ramp_d;
      read_row_q <= read_row_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.START) state_d = S_ERASE;
      S_ERASE:   if (cnt_q == CW'(ERASE_CYCLES - 1))  state_d = S_EXPOSE;
      S_EXPOSE:  if (cnt_q == CW'(EXPOSE_CYCLES - 1)) state_d = S_CONVERT;
      S_CONVERT: if (cnt_q == CW'(RAMP_CYCLES - 1))   state_d = S_READ;
      S_READ:    if (xfer && row_q == RW'(ROWS - 1))  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Phase counter restarts on every state entry; row counter only returns to
  // zero once the frame leaves READ.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    if (state_d == S_IDLE || state_d == S_READ || state_d == S_DONE) cnt_d = '0;
    row_d = row_q;
    if (state_d != S_READ)             row_d = '0;
    else if (xfer)                     row_d = row_q + 1'b1;
  end

  always_comb begin
    erase_d    = (state_d == S_ERASE);
    expose_d   = (state_d == S_EXPOSE);
    convert_d  = (state_d == S_CONVERT);
    valid_d    = (state_d == S_READ);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    ramp_d     = '0;
    read_row_d = '0;
    if (state_d == S_CONVERT) ramp_d = cnt_d[PIXEL_BITS-1:0];
    // Full-scale code held through readout so untripped comparators read max.
    if (state_d == S_READ) begin
      ramp_d     = '1;
      read_row_d = ROWS'(1) << row_d;
    end
  end

  assign bus.ERASE        = erase_q;
  assign bus.EXPOSE       = expose_q;
  assign bus.CONVERT      = convert_q;
  assign bus.DIGITAL_RAMP = ramp_q;
  assign bus.READ_ROW     = read_row_q;
  assign bus.ROW_VALID    = valid_q;
  assign bus.ROW_INDEX    = row_q;
  assign bus.BUSY         = busy_q;
  assign bus.FRAME_DONE   = done_q;
endmodule

// File: tb/tb_pixel_array_controller.sv
// Directed + randomized bench for pixel_array_controller against a frame
// timeline model (phase offsets and row progress computed arithmetically).
module tb_pixel_array_controller;
  localparam int PB = 8;
  localparam int NR = 2;
  localparam int E  = 5;
  localparam int X  = 255;
  localparam int R  = 1 << PB;

  logic CLK = 1'b0;
  logic RESET_N;
  int   tests = 0;
  int   fails = 0;

  pixel_array_controller_if #(.PIXEL_BITS(PB), .ROWS(NR)) bus ();

  pixel_array_controller #(
    .PIXEL_BITS(PB), .ROWS(NR), .ERASE_CYCLES(E), .EXPOSE_CYCLES(X)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit er, input bit ex, input bit cv,
                            input int ramp, input int rr, input bit vl, input int idx,
                            input bit by, input bit fd);
    chk({tag, ".erase"},    32'(bus.ERASE),        32'(er));
    chk({tag, ".expose"},   32'(bus.EXPOSE),       32'(ex));
    chk({tag, ".convert"},  32'(bus.CONVERT),      32'(cv));
    chk({tag, ".ramp"},     32'(bus.DIGITAL_RAMP), 32'(ramp));
    chk({tag, ".read_row"}, 32'(bus.READ_ROW),     32'(rr));
    chk({tag, ".valid"},    32'(bus.ROW_VALID),    32'(vl));
    chk({tag, ".index"},    32'(bus.ROW_INDEX),    32'(idx));
    chk({tag, ".busy"},     32'(bus.BUSY),         32'(by));
    chk({tag, ".done"},     32'(bus.FRAME_DONE),   32'(fd));
  endtask

  // stall_mode: 0 none, 1 random ROW_READY, 2 ten-cycle stall on row 0
  task automatic run_frame(input int stall_mode, input bit poke, input bit hold_start);
    int  len, stalls, stall_left, r;
    bit  rdy;
    bus.START = 1'b1;
    step();
    if (!hold_start) bus.START = 1'b0;
    len = 0; stalls = 0; r = 0;
    stall_left = (stall_mode == 2) ? 10 : 0;
    for (int t = 0; t < E + X + R; t++) begin
      len++;
      if (t < E)          expect_out("erase",   1, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (t < E + X) expect_out("expose",  0, 1, 0, 0, 0, 0, 0, 1, 0);
      else                expect_out("convert", 0, 0, 1, t - E - X, 0, 0, 0, 1, 0);
      if (!hold_start) bus.START = poke && (t == E + 7);
      step();
    end
    for (int g = 0; r < NR && g < 200; g++) begin
      len++;
      expect_out("read", 0, 0, 0, R - 1, 1 << r, 1, r, 1, 0);
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (stall_mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1'b1;
      if (!rdy) stalls++;
      bus.ROW_READY = rdy;
      step();
      if (rdy) r++;
    end
    chk("rows_transferred", 32'(r), 32'(NR));
    len++;
    expect_out("done", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("frame_len", 32'(len), 32'(E + X + R + NR + 1 + stalls));
    bus.ROW_READY = 1'b1;
    if (poke) bus.START = 1'b1;
    step();
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (poke) begin
      bus.START = 1'b0;
      step();
      expect_out("idle_after_poke", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    RESET_N       = 1'b0;
    bus.START     = 1'b0;
    bus.ROW_READY = 1'b1;
    step();
    step();
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK) RESET_N = 1'b1;
    step();
    expect_out("idle_post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b0);

    // Abort mid-CONVERT once the ramp reaches 0x40
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int g = 0; g < 1000 && bus.DIGITAL_RAMP != 8'h40; g++) step();
    chk("pre_reset_ramp",    32'(bus.DIGITAL_RAMP), 32'h40);
    chk("pre_reset_convert", 32'(bus.CONVERT),      32'd1);
    #2 RESET_N = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge CLK) RESET_N = 1'b1;
    step();
    step();
    expect_out("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    run_frame(0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
